// File: rtl/line_buffer_reader.sv
// line_buffer_reader: drains one full image line at a time from a LineBuffer FIFO
// into a valid/ready pixel stream tagged with line and frame markers.
module line_buffer_reader #(
   parameter int DATA_WIDTH  = 14,
   parameter int FIFO_WIDTH  = 8,
   parameter int LINE_WIDTH  = 256,
   parameter int FRAME_LINES = 4
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic [FIFO_WIDTH:0]   fifo_usedw,
   input  logic                  fifo_empty,
   output logic                  fifo_rdreq,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sol,
   output logic                  m_eol,
   output logic                  m_sof,
   output logic                  m_eof,
   output logic                  busy,
   output logic                  underflow
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_LINE = 2'd1;
   localparam logic [1:0] BURST     = 2'd2;
   localparam logic [1:0] DRAIN     = 2'd3;
   localparam int CW  = FIFO_WIDTH + 1;
   localparam int LCW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
   localparam logic [CW-1:0]  LW    = CW'(LINE_WIDTH);
   localparam logic [CW-1:0]  LW_M1 = CW'(LINE_WIDTH - 1);
   localparam logic [LCW-1:0] FL_M1 = LCW'(FRAME_LINES - 1);

   logic [1:0]            state;
   logic [CW-1:0]         rd_cnt;
   logic [CW-1:0]         px_cnt;
   logic [LCW-1:0]        line_cnt;
   logic                  inflight;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] s0;
   logic [DATA_WIDTH-1:0] s1;
   logic                  pop;
   logic [2:0]            level;

   assign pop        = m_valid && m_ready;
   // occupancy the skid buffer will have once this cycle's pop and landing read settle
   assign level      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
   assign fifo_rdreq = (state == BURST) && (rd_cnt < LW) && !fifo_empty && (level < 3'd2);
   assign m_valid    = (occ != 2'd0);
   assign m_data     = s0;
   assign m_sol      = m_valid && (px_cnt == '0);
   assign m_eol      = m_valid && (px_cnt == LW_M1);
   assign m_sof      = m_sol && (line_cnt == '0);
   assign m_eof      = m_eol && (line_cnt == FL_M1);
   assign busy       = (state == BURST) || (occ != 2'd0);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state  <= IDLE;
         rd_cnt <= '0;
      end else begin
         case (state)
            IDLE:      state <= enable ? WAIT_LINE : IDLE;
            WAIT_LINE: begin
               if (enable && (fifo_usedw >= LW)) begin
                  state  <= BURST;
                  rd_cnt <= '0;
               end
            end
            BURST: begin
               if (fifo_rdreq) rd_cnt <= rd_cnt + 1'b1;
               if (fifo_rdreq && (rd_cnt == LW_M1)) state <= DRAIN;
            end
            default: begin
               if ((occ == 2'd0) && !inflight) state <= enable ? WAIT_LINE : IDLE;
            end
         endcase
      end
   end

   // two-entry skid: s0 is the head shown on m_data, s1 backs it up during stalls
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
         s0       <= '0;
         s1       <= '0;
      end else begin
         inflight <= fifo_rdreq;
         occ      <= occ + {1'b0, inflight} - {1'b0, pop};
         s0       <= pop ? ((inflight && occ == 2'd1) ? fifo_data : s1)
                         : ((inflight && occ == 2'd0) ? fifo_data : s0);
         s1       <= (inflight && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) ? fifo_data : s1;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         px_cnt   <= '0;
         line_cnt <= '0;
      end else if (pop) begin
         px_cnt <= (px_cnt == LW_M1) ? '0 : px_cnt + 1'b1;
         if (px_cnt == LW_M1) line_cnt <= (line_cnt == FL_M1) ? '0 : line_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) underflow <= 1'b0;
      else if (fifo_rdreq && fifo_empty) underflow <= 1'b1;
   end
endmodule
